clk_gate_ctrl: RTL
==================

Name: clk_gate_ctrl

Overview:
- Power-management sequencer that drives the `active` input of the synchronized clock-gating cell (`en_as_clk_gating`).
- Merges REQ_NUM requester wake requests into one gate enable.
- Holds the clock on through a programmable idle hysteresis.
- Hides the synchronizer and gate latency behind a per-requester ack, so a requester only proceeds once the gated clock is guaranteed running.

Parameters:
- REQ_NUM, 4, number of requesters.
- IDLE_CNT_W, 8, width of the idle-hysteresis threshold and counter.
- WAKE_LAT, 3, cycles from active rising (or falling) to the gated clock toggling (or stopped): 2 synchronizer stages plus 1 gate cycle. Legal range is 1 or more.

Ports:
- clk, input, 1, free-running clock; same source as the gate's raw_clk.
- rst_n, input, 1, asynchronous active-low reset.
- req, input, REQ_NUM, level wake request per requester; once raised, held until ack is seen.
- ack, output, REQ_NUM, clock-running grant per requester.
- force_on, input, 1, keeps the clock on regardless of req; treated as an extra requester.
- idle_thresh, input, IDLE_CNT_W, idle cycles tolerated before gating off; quasi-static.
- active, output, 1, gate enable to en_as_clk_gating.
- clk_on, output, 1, status; high in ON and IDLE.
- fsm_state, output, 3, current state encoding for debug.

Behaviour:
- Clock and reset: one clock `clk`; asynchronous active-low reset `rst_n`.
- Reset values: state OFF, active=0, ack=0, clk_on=0, timer=0.
- `any_req` = (|req) or force_on.
- `active` is a registered output: active=1 in WAKE, ON and IDLE; active=0 in OFF and DRAIN.
- `ack` is combinational from the registered state: ack[i] = req[i] and clk_on. There is no ack in WAKE, DRAIN or OFF.
- States (one shared down-counter, `timer`):
  - OFF: any_req -> WAKE, load timer = WAKE_LAT-1.
  - WAKE: timer decrements each cycle; at timer==0 -> ON. Requests dropping mid-wake are ignored; the wake completes.
  - ON:
    - any_req -> stay ON.
    - No request and idle_thresh==0 -> DRAIN, load timer = WAKE_LAT-1.
    - No request and idle_thresh!=0 -> IDLE, load timer = idle_thresh-1.
  - IDLE:
    - any_req -> ON in the next cycle. ack is already valid this cycle, since the clock is still running.
    - Otherwise timer==0 -> DRAIN, load timer = WAKE_LAT-1.
    - Otherwise decrement.
  - DRAIN: timer counts the gate-off latency; at timer==0 -> OFF. Requests are held pending, not acked. After OFF they re-wake with the normal WAKE latency.
- Minimum latency, OFF to first ack: req seen in cycle 0 -> ack in cycle WAKE_LAT+1.
- Clock stays on for exactly idle_thresh cycles after the last request drops.
- Simultaneous events:
  - req rising in the same cycle IDLE expires: the request wins, state -> ON.
  - req rising in the cycle ON -> DRAIN is decided: that request is sampled in the next state and sees DRAIN.
- Reset mid-operation: immediate return to OFF with active=0. The downstream synchronizer resets to its own RST_VAL.
- No arithmetic wrap: timer loads never underflow because WAKE_LAT is at least 1, and idle_thresh==0 is special-cased.

Optional Feature:
- Macro: CLK_GATE_CTRL_STAT_EN.
- When defined:
  - Adds output wake_cnt[15:0]: a saturating count of OFF->WAKE transitions.
  - Adds output on_cyc[31:0]: a saturating count of cycles with active=1.
  - Both reset to 0.
- When undefined: neither port nor the counters exist. Functional behaviour is identical.

Decomposition:
- Package clk_gate_pkg holds:
  - State enum: OFF=0, WAKE=1, ON=2, IDLE=3, DRAIN=4.
  - Constant FSM_W=3.
  - Default WAKE_LAT.
- One sub-module, clk_gate_timer: a loadable down-counter with load, load_val, dec and zero outputs, parameterized width = max(IDLE_CNT_W, $clog2(WAKE_LAT)).
- The FSM stays in the top module.

Test Plan:
- Cold wake: reset, WAKE_LAT=3, req=4'b0001 at cycle 10 -> active=1 at cycle 11; ack[0]=1 at cycle 14; ack[3:1]=0.
- Idle hysteresis: idle_thresh=5, drop all req at cycle 20 -> active stays 1 through cycle 25, active=0 from cycle 26; OFF reached 3 cycles later.
- Idle re-hit: idle_thresh=8, req drops then req[2] rises 4 cycles later -> ack[2] in the same cycle; active never drops; fsm_state returns to ON.
- Drain hold-off: req[1] rises during DRAIN -> no ack until after OFF -> WAKE -> ON, i.e. ack 4 or more cycles after DRAIN ends; no active glitch.
- Boundaries:
  - idle_thresh=0: drop req -> DRAIN directly, active=0 one cycle after the drop.
  - force_on=1 with req=0 for 100 cycles -> active held at 1.
- Reset mid-WAKE: assert rst_n=0 for 1 cycle at timer=1 -> active=0 and ack=0 immediately. With CLK_GATE_CTRL_STAT_EN, wake_cnt=0.

Source files
------------

// File: rtl/clk_gate_pkg.sv
// Shared definitions for the clock-gate enable sequencer.
package clk_gate_pkg;

  localparam int FSM_W        = 3;
  localparam int WAKE_LAT_DEF = 3;

  typedef enum logic [FSM_W-1:0] {
    OFF   = 3'd0,
    WAKE  = 3'd1,
    ON    = 3'd2,
    IDLE  = 3'd3,
    DRAIN = 3'd4
  } gate_state_e;

  // Larger of two integers, used for elaboration-time width sizing.
  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/clk_gate_timer.sv
// Loadable down-counter shared by the wake, idle and drain phases.
// Load takes priority over decrement; decrement stops at zero.
module clk_gate_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_r;

  // Count register: load a new interval or step toward zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != '0)) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == '0);

endmodule

// File: rtl/clk_gate_ctrl.sv
// Sequencer driving the enable of the synchronized clock-gating cell.
// Merges wake requests, applies idle hysteresis and hides the gate
// latency behind per-requester acks.
// Optional statistics counters: define CLK_GATE_CTRL_STAT_EN.
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int REQ_NUM    = 4,
  parameter int IDLE_CNT_W = 8,
  parameter int WAKE_LAT   = WAKE_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REQ_NUM-1:0]    req,
  output logic [REQ_NUM-1:0]    ack,
  input  logic                  force_on,
  input  logic [IDLE_CNT_W-1:0] idle_thresh,
  output logic                  active,
  output logic                  clk_on,
  output logic [FSM_W-1:0]      fsm_state
`ifdef CLK_GATE_CTRL_STAT_EN
  ,
  output logic [15:0]           wake_cnt,
  output logic [31:0]           on_cyc
`endif
);

  // Timer must hold both idle_thresh-1 and WAKE_LAT-1.
  localparam int TW = max_int(max_int(IDLE_CNT_W, $clog2(WAKE_LAT)), 1);
  localparam logic [TW-1:0] WAKE_LOAD = TW'(WAKE_LAT - 1);

  gate_state_e   state_r;
  logic          active_r;
  logic          clk_on_r;
  logic          any_req_s;
  logic          tmr_load_s;
  logic [TW-1:0] tmr_val_s;
  logic          tmr_dec_s;
  logic          tmr_zero_s;
  logic [TW-1:0] idle_load_s;

  assign any_req_s   = (|req) | force_on;
  assign idle_load_s = TW'(idle_thresh) - TW'(1);

  // Timer control: load on phase entry, decrement while a phase runs.
  always_comb begin
    tmr_load_s = 1'b0;
    tmr_val_s  = WAKE_LOAD;
    tmr_dec_s  = 1'b0;
    case (state_r)
      OFF: begin
        if (any_req_s) begin
          tmr_load_s = 1'b1;
        end else begin
          tmr_load_s = 1'b0;
        end
      end
      WAKE: begin
        tmr_dec_s = 1'b1;
      end
      ON: begin
        if (!any_req_s) begin
          tmr_load_s = 1'b1;
          if (idle_thresh == '0) begin
            tmr_val_s = WAKE_LOAD;
          end else begin
            tmr_val_s = idle_load_s;
          end
        end else begin
          tmr_load_s = 1'b0;
        end
      end
      IDLE: begin
        if (any_req_s) begin
          tmr_load_s = 1'b0;
        end else if (tmr_zero_s) begin
          tmr_load_s = 1'b1;
        end else begin
          tmr_dec_s = 1'b1;
        end
      end
      DRAIN: begin
        tmr_dec_s = 1'b1;
      end
      default: begin
        tmr_load_s = 1'b0;
      end
    endcase
  end

  clk_gate_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .dec      (tmr_dec_s),
    .zero     (tmr_zero_s)
  );

  // Main sequencer; active and clk_on are registered with the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= OFF;
      active_r <= 1'b0;
      clk_on_r <= 1'b0;
    end else begin
      case (state_r)
        OFF: begin
          if (any_req_s) begin
            state_r  <= WAKE;
            active_r <= 1'b1;
            clk_on_r <= 1'b0;
          end else begin
            state_r  <= OFF;
            active_r <= 1'b0;
            clk_on_r <= 1'b0;
          end
        end
        WAKE: begin
          // Requests dropping here are ignored; the wake always completes.
          if (tmr_zero_s) begin
            state_r  <= ON;
            active_r <= 1'b1;
            clk_on_r <= 1'b1;
          end else begin
            state_r  <= WAKE;
            active_r <= 1'b1;
            clk_on_r <= 1'b0;
          end
        end
        ON: begin
          if (any_req_s) begin
            state_r  <= ON;
            active_r <= 1'b1;
            clk_on_r <= 1'b1;
          end else if (idle_thresh == '0) begin
            state_r  <= DRAIN;
            active_r <= 1'b0;
            clk_on_r <= 1'b0;
          end else begin
            state_r  <= IDLE;
            active_r <= 1'b1;
            clk_on_r <= 1'b1;
          end
        end
        IDLE: begin
          // A request arriving on the expiry cycle still wins.
          if (any_req_s) begin
            state_r  <= ON;
            active_r <= 1'b1;
            clk_on_r <= 1'b1;
          end else if (tmr_zero_s) begin
            state_r  <= DRAIN;
            active_r <= 1'b0;
            clk_on_r <= 1'b0;
          end else begin
            state_r  <= IDLE;
            active_r <= 1'b1;
            clk_on_r <= 1'b1;
          end
        end
        DRAIN: begin
          // Requests stay pending until the gate is fully off.
          if (tmr_zero_s) begin
            state_r  <= OFF;
            active_r <= 1'b0;
            clk_on_r <= 1'b0;
          end else begin
            state_r  <= DRAIN;
            active_r <= 1'b0;
            clk_on_r <= 1'b0;
          end
        end
        default: begin
          state_r  <= OFF;
          active_r <= 1'b0;
          clk_on_r <= 1'b0;
        end
      endcase
    end
  end

  assign active    = active_r;
  assign clk_on    = clk_on_r;
  assign fsm_state = state_r;
  assign ack       = req & {REQ_NUM{clk_on_r}};

`ifdef CLK_GATE_CTRL_STAT_EN
  logic [15:0] wake_cnt_r;
  logic [31:0] on_cyc_r;

  // Saturating counters of wake-ups and enabled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wake_cnt_r <= 16'd0;
      on_cyc_r   <= 32'd0;
    end else begin
      if ((state_r == OFF) && any_req_s && (wake_cnt_r != 16'hFFFF)) begin
        wake_cnt_r <= wake_cnt_r + 16'd1;
      end else begin
        wake_cnt_r <= wake_cnt_r;
      end
      if (active_r && (on_cyc_r != 32'hFFFF_FFFF)) begin
        on_cyc_r <= on_cyc_r + 32'd1;
      end else begin
        on_cyc_r <= on_cyc_r;
      end
    end
  end

  assign wake_cnt = wake_cnt_r;
  assign on_cyc   = on_cyc_r;
`endif

endmodule
